tpu_tile_sequencer: RTL and testbench
=====================================

Name: tpu_tile_sequencer

Overview:
- Parametrised next-generation command sequencer for the systolic TPU core.
- Accepts matrix-tile commands from the host and drives four pipelined stages:
  - B: weight load
  - A: activation stream and weight switch
  - C: bias/accumulator read
  - D: writeback tracking
- Unlike the previous sequencer, activation, bias and writeback lengths follow the command's len_m (1..255 rows) instead of a fixed array width.
- Command FIFO depth and writeback-queue depth are parametrised.
- Inter-stage handoff is back-pressured, so no trigger is ever dropped.

Parameters:
- ADDR_WIDTH, 10, scratchpad address width.
- SYSTOLIC_ARRAY_WIDTH (W), 16, array dimension; weight rows loaded per command.
- CMD_FIFO_DEPTH, 4, host command FIFO entries; power of 2, at least 2.
- WB_QUEUE_DEPTH, 4, maximum commands in flight between B pop and D completion.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  host command strobe.
- cmd_data  in  24+4*ADDR_WIDTH  fields, LSB first: len_m[7:0], len_k[7:0], len_n[7:0], addr_a, addr_b, addr_c, addr_d.
- cmd_ready  out  1  FIFO can accept.
- cmd_err  out  1  1-cycle pulse: command rejected.
- busy  out  1  any stage, FIFO or queue non-empty.
- done_irq  out  1  1-cycle pulse per completed command.
- ctrl_rd_en_b, ctrl_rd_addr_b  out  1, ADDR_WIDTH  weight read.
- ctrl_b_accept_w, ctrl_b_weight_index  out  1, clog2(W)  weight shift-in.
- ctrl_rd_en_a, ctrl_rd_addr_a  out  1, ADDR_WIDTH  activation read.
- ctrl_a_switch  out  1  weight-bank switch pulse.
- ctrl_a_valid, ctrl_psum_valid  out  1 each.
- ctrl_rd_en_c, ctrl_rd_addr_c, ctrl_c_valid  out  1, ADDR_WIDTH, 1.
- ctrl_vpu_mode  out  3  constant 3'b001.
- core_writeback_valid  in  1  one result row produced.
- ctrl_wr_addr_d  out  ADDR_WIDTH  writeback address.
- ctrl_row_mask, ctrl_col_mask  out  W each.
- perf_busy_cycles  out  32; perf_cmds_done  out  16.

Behaviour:
- Reset: every output 0 except cmd_ready=1 and ctrl_vpu_mode=001. FIFO, queue, counters and stage states cleared. Reset mid-operation aborts all stages the next cycle; no done_irq is issued for aborted commands.

FIFO:
- Push when cmd_valid && cmd_ready; cmd_ready = count < CMD_FIFO_DEPTH.
- A handshake with len_m, len_k or len_n equal to 0 is not stored; cmd_err pulses the next cycle.
- Pointers wrap modulo depth. Simultaneous push and pop keeps count unchanged.

Stage B states: IDLE, LOAD, HANDOFF.
- IDLE→LOAD: pop when FIFO non-empty and inflight < WB_QUEUE_DEPTH.
- inflight increments on pop and decrements on done_irq.
- LOAD: ctrl_rd_en_b=1 for W cycles, starting the cycle after the pop, with ctrl_rd_addr_b = addr_b + i.
- ctrl_b_accept_w follows ctrl_rd_en_b one cycle later. ctrl_b_weight_index is W-1 down to 0, aligned with accept_w.
- HANDOFF: assert trigger to A; hold it until A accepts.
- On accept: if a pop condition holds, pop and return to LOAD; else go to IDLE.

Stage A:
- Accepts the trigger when it is idle, or in its last read cycle, and C's pending slot is free.
- Accept at cycle t → ctrl_rd_en_a=1 for cycles t+1 .. t+len_m, with ctrl_rd_addr_a = addr_a + i.
- ctrl_a_switch pulses at t+1.
- ctrl_a_valid and ctrl_psum_valid equal ctrl_rd_en_a delayed 1 cycle.
- ctrl_row_mask bit i = (i < min(len_k, W)) while A reads; otherwise 0.

Stage C:
- On A's final read, the job enters C. C starts the next cycle if idle; otherwise it is held in a 1-entry pending slot.
- C reads len_m rows: ctrl_rd_addr_c = addr_c + i. ctrl_c_valid is the read enable delayed 1.
- After the last read the job is pushed to the D queue; the queue never overflows because of the inflight limit.

Stage D:
- Idle with queue non-empty → pop and load ctrl_wr_addr_d = addr_d.
- Each core_writeback_valid increments the address and the row count.
- At row len_m: done_irq pulses the next cycle, D goes idle, and it may pop again that cycle.
- core_writeback_valid while D is idle is ignored.
- ctrl_col_mask bit i = (i < min(len_n, W)) while D is active.

Widths:
- Address increments wrap modulo 2^ADDR_WIDTH.
- Row counters are 8-bit.

Optional Feature:
- Macro: TPU_SEQ_PERF_COUNTERS_EN.
- Defined:
  - perf_busy_cycles increments every cycle busy=1, saturating at 2^32-1.
  - perf_cmds_done increments on each done_irq and wraps.
  - Both clear on rst.
- Undefined: both ports are constant 0 and no counter logic is built.

Test Plan:
- Single command len_m=16, len_k=16, len_n=16, addr_b=0x40 → rd_en_b high 16 cycles at 0x40..0x4F; weight_index 15..0; switch pulse 1 cycle after HANDOFF accept; 16 writebacks → one done_irq; busy falls.
- len_m=5, len_k=3, len_n=7 → A and C read 5 rows each; row_mask=0x0007; col_mask=0x007F; done_irq after 5th writeback.
- Push 5 commands back-to-back with CMD_FIFO_DEPTH=4 and no writebacks → cmd_ready low after 4th; inflight caps pops at 4; done_irq count=5 after all writebacks.
- Command with len_k=0 → cmd_err pulse; FIFO count unchanged; no stage activity.
- Command A len_m=40 followed by command B len_m=2 → B's C read held pending until A's C finishes; no trigger lost; 2 done_irq in order A, B.
- Assert rst mid-LOAD → all outputs 0 next cycle, cmd_ready=1; with TPU_SEQ_PERF_COUNTERS_EN defined, perf counters read 0.

Source files
------------

// File: rtl/tpu_tile_sequencer.sv
// tpu_tile_sequencer: host command FIFO feeding weight-load (B), activation (A), bias (C) and writeback (D) stages.
// Optional performance counters are enabled by defining TPU_SEQ_PERF_COUNTERS_EN.
module tpu_tile_sequencer #(
  parameter int ADDR_WIDTH = 10,
  parameter int SYSTOLIC_ARRAY_WIDTH = 16,
  parameter int CMD_FIFO_DEPTH = 4,
  parameter int WB_QUEUE_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd_valid,
  input  logic [24+4*ADDR_WIDTH-1:0] cmd_data,
  output logic cmd_ready,
  output logic cmd_err,
  output logic busy,
  output logic done_irq,
  output logic ctrl_rd_en_b,
  output logic [ADDR_WIDTH-1:0] ctrl_rd_addr_b,
  output logic ctrl_b_accept_w,
  output logic [$clog2(SYSTOLIC_ARRAY_WIDTH)-1:0] ctrl_b_weight_index,
  output logic ctrl_rd_en_a,
  output logic [ADDR_WIDTH-1:0] ctrl_rd_addr_a,
  output logic ctrl_a_switch,
  output logic ctrl_a_valid,
  output logic ctrl_psum_valid,
  output logic ctrl_rd_en_c,
  output logic [ADDR_WIDTH-1:0] ctrl_rd_addr_c,
  output logic ctrl_c_valid,
  output logic [2:0] ctrl_vpu_mode,
  input  logic core_writeback_valid,
  output logic [ADDR_WIDTH-1:0] ctrl_wr_addr_d,
  output logic [SYSTOLIC_ARRAY_WIDTH-1:0] ctrl_row_mask,
  output logic [SYSTOLIC_ARRAY_WIDTH-1:0] ctrl_col_mask,
  output logic [31:0] perf_busy_cycles,
  output logic [15:0] perf_cmds_done
);
  localparam int AW = ADDR_WIDTH, W = SYSTOLIC_ARRAY_WIDTH, CW = 24 + 4*AW, TW = 16 + 2*AW, QW = 16 + AW;
  localparam int FPW = $clog2(CMD_FIFO_DEPTH), FCW = FPW + 1;
  localparam int QPW = WB_QUEUE_DEPTH > 1 ? $clog2(WB_QUEUE_DEPTH) : 1;
  localparam int IW = $clog2(WB_QUEUE_DEPTH + 1), WI = $clog2(W);
  typedef enum logic [1:0] {B_IDLE, B_LOAD, B_HAND} b_state_t;
  logic [CW-1:0] fifo [CMD_FIFO_DEPTH];
  logic [FPW-1:0] wp, rp;
  logic [FCW-1:0] fcnt;
  logic push, pop, bad, pop_ok, b_trig, a_acc, a_last, c_last, c_free, q_push, q_pop, d_fin, d_free;
  logic [IW-1:0] inflight, qcnt;
  b_state_t b_st, b_nx;
  logic [CW-1:0] b_cmd;
  logic [WI-1:0] b_cnt;
  logic a_active, c_active, c_pend, d_active;
  logic [7:0] a_cnt, a_k, c_cnt, d_cnt, d_m, d_n;
  logic [AW-1:0] a_addr;
  logic [TW-1:0] a_tail, pend_tail, c_tail;
  logic [QW-1:0] q [WB_QUEUE_DEPTH];
  logic [QPW-1:0] qwp, qrp;
  assign cmd_ready = fcnt < FCW'(CMD_FIFO_DEPTH);
  assign bad = cmd_valid && cmd_ready && (cmd_data[7:0] == 8'd0 || cmd_data[15:8] == 8'd0 || cmd_data[23:16] == 8'd0);
  assign push = cmd_valid && cmd_ready && !bad;
  assign pop_ok = fcnt != '0 && inflight < IW'(WB_QUEUE_DEPTH);
  assign pop = pop_ok && (b_st == B_IDLE || (b_st == B_HAND && a_acc));
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      fcnt <= '0;
      cmd_err <= 1'b0;
      inflight <= '0;
    end else begin
      if (push) begin
        fifo[wp] <= cmd_data;
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      fcnt <= fcnt + FCW'(push) - FCW'(pop);
      cmd_err <= bad;
      inflight <= inflight + IW'(pop) - IW'(done_irq);
    end
  end
  always_ff @(posedge clk) b_st <= rst ? B_IDLE : b_nx;
  always_comb begin
    b_nx = b_st == B_IDLE ? (pop ? B_LOAD : B_IDLE)
         : b_st == B_LOAD ? (b_cnt == WI'(W-1) ? B_HAND : B_LOAD)
         : (a_acc ? (pop ? B_LOAD : B_IDLE) : B_HAND);
  end
  always_comb begin
    ctrl_rd_en_b = b_st == B_LOAD;
    b_trig = b_st == B_HAND;
  end
  assign ctrl_rd_addr_b = ctrl_rd_en_b ? b_cmd[24+AW +: AW] + AW'(b_cnt) : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_b_accept_w <= 1'b0;
      ctrl_b_weight_index <= '0;
    end else begin
      ctrl_b_accept_w <= ctrl_rd_en_b;
      ctrl_b_weight_index <= ctrl_rd_en_b ? WI'(W-1) - b_cnt : '0;
    end
    if (pop) begin
      b_cmd <= fifo[rp];
      b_cnt <= '0;
    end else if (ctrl_rd_en_b) b_cnt <= b_cnt + 1'b1;
  end
  // A may start a new job on its own last read only if the finishing job can go straight into C.
  assign a_last = a_active && a_cnt == a_tail[7:0] - 8'd1;
  assign c_last = c_active && c_cnt == c_tail[7:0] - 8'd1;
  assign c_free = !c_active || c_last;
  assign a_acc = b_trig && (!a_active || a_last) && !c_pend && (!a_last || c_free);
  always_ff @(posedge clk) begin
    if (rst) begin
      a_active <= 1'b0;
      ctrl_a_valid <= 1'b0;
    end else begin
      ctrl_a_valid <= a_active;
      if (a_acc) begin
        a_active <= 1'b1;
        a_cnt <= '0;
        a_k <= b_cmd[15:8];
        a_addr <= b_cmd[24 +: AW];
        a_tail <= {b_cmd[24+3*AW +: AW], b_cmd[24+2*AW +: AW], b_cmd[23:16], b_cmd[7:0]};
      end else if (a_last) a_active <= 1'b0;
      else if (a_active) a_cnt <= a_cnt + 8'd1;
    end
  end
  assign ctrl_rd_en_a = a_active;
  assign ctrl_rd_addr_a = a_active ? a_addr + AW'(a_cnt) : '0;
  assign ctrl_a_switch = a_active && a_cnt == 8'd0;
  assign ctrl_psum_valid = ctrl_a_valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      c_active <= 1'b0;
      c_pend <= 1'b0;
      ctrl_c_valid <= 1'b0;
    end else begin
      ctrl_c_valid <= c_active;
      if (c_free) begin
        c_active <= c_pend || a_last;
        c_tail <= c_pend ? pend_tail : a_tail;
        c_cnt <= '0;
      end else c_cnt <= c_cnt + 8'd1;
      if (a_last && (c_pend || !c_free)) begin
        c_pend <= 1'b1;
        pend_tail <= a_tail;
      end else if (c_free) c_pend <= 1'b0;
    end
  end
  assign ctrl_rd_en_c = c_active;
  assign ctrl_rd_addr_c = c_active ? c_tail[16 +: AW] + AW'(c_cnt) : '0;
  assign q_push = c_last;
  assign d_fin = d_active && core_writeback_valid && d_cnt == d_m - 8'd1;
  assign d_free = !d_active || d_fin;
  assign q_pop = d_free && qcnt != '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      qwp <= '0;
      qrp <= '0;
      qcnt <= '0;
      d_active <= 1'b0;
      done_irq <= 1'b0;
      ctrl_wr_addr_d <= '0;
    end else begin
      if (q_push) begin
        q[qwp] <= {c_tail[16+AW +: AW], c_tail[15:0]};
        qwp <= qwp == QPW'(WB_QUEUE_DEPTH-1) ? '0 : qwp + 1'b1;
      end
      if (q_pop) qrp <= qrp == QPW'(WB_QUEUE_DEPTH-1) ? '0 : qrp + 1'b1;
      qcnt <= qcnt + IW'(q_push) - IW'(q_pop);
      done_irq <= d_fin;
      if (q_pop) begin
        d_active <= 1'b1;
        d_cnt <= '0;
        d_m <= q[qrp][7:0];
        d_n <= q[qrp][15:8];
        ctrl_wr_addr_d <= q[qrp][16 +: AW];
      end else begin
        if (d_fin) d_active <= 1'b0;
        if (d_active && core_writeback_valid) begin
          d_cnt <= d_cnt + 8'd1;
          ctrl_wr_addr_d <= ctrl_wr_addr_d + 1'b1;
        end
      end
    end
  end
  always_comb begin
    ctrl_row_mask = '0;
    ctrl_col_mask = '0;
    for (int i = 0; i < W; i++) begin
      ctrl_row_mask[i] = a_active && (i < int'(a_k));
      ctrl_col_mask[i] = d_active && (i < int'(d_n));
    end
  end
  assign ctrl_vpu_mode = 3'b001;
  assign busy = fcnt != '0 || b_st != B_IDLE || a_active || c_active || c_pend || qcnt != '0 || d_active;
`ifdef TPU_SEQ_PERF_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_busy_cycles <= '0;
      perf_cmds_done <= '0;
    end else begin
      if (busy && perf_busy_cycles != '1) perf_busy_cycles <= perf_busy_cycles + 32'd1;
      if (done_irq) perf_cmds_done <= perf_cmds_done + 16'd1;
    end
  end
`else
  assign perf_busy_cycles = '0;
  assign perf_cmds_done = '0;
`endif
endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// tb_tpu_tile_sequencer: directed checks of the tile sequencer with default parameters.
module tb_tpu_tile_sequencer;
`ifdef TPU_SEQ_PERF_COUNTERS_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clk, rst, cmd_valid, cmd_ready, cmd_err, busy, done_irq;
  logic [63:0] cmd_data;
  logic ctrl_rd_en_b, ctrl_b_accept_w, ctrl_rd_en_a, ctrl_a_switch, ctrl_a_valid, ctrl_psum_valid;
  logic ctrl_rd_en_c, ctrl_c_valid, core_writeback_valid;
  logic [9:0] ctrl_rd_addr_b, ctrl_rd_addr_a, ctrl_rd_addr_c, ctrl_wr_addr_d;
  logic [3:0] ctrl_b_weight_index;
  logic [2:0] ctrl_vpu_mode;
  logic [15:0] ctrl_row_mask, ctrl_col_mask, perf_cmds_done;
  logic [31:0] perf_busy_cycles;
  int n_cmp = 0, n_err = 0, done_cnt = 0, n, base;

  tpu_tile_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .cmd_err(cmd_err), .busy(busy), .done_irq(done_irq), .ctrl_rd_en_b(ctrl_rd_en_b),
    .ctrl_rd_addr_b(ctrl_rd_addr_b), .ctrl_b_accept_w(ctrl_b_accept_w),
    .ctrl_b_weight_index(ctrl_b_weight_index), .ctrl_rd_en_a(ctrl_rd_en_a),
    .ctrl_rd_addr_a(ctrl_rd_addr_a), .ctrl_a_switch(ctrl_a_switch), .ctrl_a_valid(ctrl_a_valid),
    .ctrl_psum_valid(ctrl_psum_valid), .ctrl_rd_en_c(ctrl_rd_en_c), .ctrl_rd_addr_c(ctrl_rd_addr_c),
    .ctrl_c_valid(ctrl_c_valid), .ctrl_vpu_mode(ctrl_vpu_mode),
    .core_writeback_valid(core_writeback_valid), .ctrl_wr_addr_d(ctrl_wr_addr_d),
    .ctrl_row_mask(ctrl_row_mask), .ctrl_col_mask(ctrl_col_mask),
    .perf_busy_cycles(perf_busy_cycles), .perf_cmds_done(perf_cmds_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk) if (done_irq) done_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk(input int m, k, nn, a, b, c, d);
    return {d[9:0], c[9:0], b[9:0], a[9:0], nn[7:0], k[7:0], m[7:0]};
  endfunction

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_data = '0;
    core_writeback_valid = 1'b0;
    repeat (2) tick();
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_vpu", ctrl_vpu_mode, 3'b001);
    chk("rst_done", done_irq, 0);
    chk("rst_rd_en_b", ctrl_rd_en_b, 0);
    chk("rst_perf_busy", perf_busy_cycles, 0);
    rst = 1'b0;
    tick();
    // single full-width command
    cmd_valid = 1'b1;
    cmd_data = mk(16, 16, 16, 'h100, 'h40, 'h200, 'h300);
    tick();
    cmd_valid = 1'b0;
    chk("t1_busy", busy, 1);
    chk("t1_b_idle", ctrl_rd_en_b, 0);
    for (int k = 1; k <= 17; k++) begin
      tick();
      chk("t1_b_rd_en", ctrl_rd_en_b, k <= 16);
      if (k <= 16) chk("t1_b_addr", ctrl_rd_addr_b, 'h40 + k - 1);
      chk("t1_b_accept", ctrl_b_accept_w, k >= 2);
      if (k >= 2) chk("t1_b_index", ctrl_b_weight_index, 17 - k);
    end
    tick();
    chk("t1_switch", ctrl_a_switch, 1);
    chk("t1_a_rd_en", ctrl_rd_en_a, 1);
    chk("t1_a_addr0", ctrl_rd_addr_a, 'h100);
    chk("t1_row_mask", ctrl_row_mask, 'hFFFF);
    chk("t1_a_valid0", ctrl_a_valid, 0);
    tick();
    chk("t1_switch_off", ctrl_a_switch, 0);
    chk("t1_a_valid1", ctrl_a_valid, 1);
    chk("t1_psum_valid", ctrl_psum_valid, 1);
    chk("t1_a_addr1", ctrl_rd_addr_a, 'h101);
    for (int i = 0; i < 100 && !ctrl_rd_en_c; i++) tick();
    chk("t1_c_start", ctrl_rd_en_c, 1);
    chk("t1_c_addr0", ctrl_rd_addr_c, 'h200);
    chk("t1_c_valid0", ctrl_c_valid, 0);
    tick();
    chk("t1_c_addr1", ctrl_rd_addr_c, 'h201);
    chk("t1_c_valid1", ctrl_c_valid, 1);
    for (int i = 0; i < 100 && ctrl_col_mask == 16'h0; i++) tick();
    chk("t1_col_mask", ctrl_col_mask, 'hFFFF);
    chk("t1_wr_addr", ctrl_wr_addr_d, 'h300);
    core_writeback_valid = 1'b1;
    repeat (15) tick();
    chk("t1_no_done_early", done_irq, 0);
    tick();
    core_writeback_valid = 1'b0;
    chk("t1_done", done_irq, 1);
    chk("t1_wr_addr_end", ctrl_wr_addr_d, 'h310);
    chk("t1_col_mask_off", ctrl_col_mask, 0);
    tick();
    chk("t1_done_pulse", done_irq, 0);
    chk("t1_busy_fall", busy, 0);
    chk("t1_perf_cmds", perf_cmds_done, PERF ? 1 : 0);
    chk("t1_perf_busy", perf_busy_cycles != 0, PERF);
    core_writeback_valid = 1'b1;
    tick();
    core_writeback_valid = 1'b0;
    tick();
    chk("idle_wb_done", done_irq, 0);
    chk("idle_wb_addr", ctrl_wr_addr_d, 'h310);
    // short command with narrow masks and writeback address wrap
    cmd_valid = 1'b1;
    cmd_data = mk(5, 3, 7, 'h010, 'h020, 'h030, 'h3FE);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 100 && !ctrl_rd_en_a; i++) tick();
    chk("t2_switch", ctrl_a_switch, 1);
    chk("t2_row_mask", ctrl_row_mask, 'h0007);
    chk("t2_a_addr", ctrl_rd_addr_a, 'h010);
    n = 0;
    while (ctrl_rd_en_a && n < 300) begin n++; tick(); end
    chk("t2_a_rows", n, 5);
    chk("t2_c_start", ctrl_rd_en_c, 1);
    chk("t2_c_addr", ctrl_rd_addr_c, 'h030);
    n = 0;
    while (ctrl_rd_en_c && n < 300) begin n++; tick(); end
    chk("t2_c_rows", n, 5);
    for (int i = 0; i < 100 && ctrl_col_mask == 16'h0; i++) tick();
    chk("t2_col_mask", ctrl_col_mask, 'h007F);
    chk("t2_wr_addr", ctrl_wr_addr_d, 'h3FE);
    core_writeback_valid = 1'b1;
    repeat (4) tick();
    chk("t2_no_done", done_irq, 0);
    chk("t2_wr_wrap", ctrl_wr_addr_d, 'h002);
    tick();
    core_writeback_valid = 1'b0;
    chk("t2_done", done_irq, 1);
    tick();
    chk("t2_busy", busy, 0);
    // zero-length command is rejected
    cmd_valid = 1'b1;
    cmd_data = mk(4, 0, 4, 'h0, 'h0, 'h0, 'h0);
    tick();
    cmd_valid = 1'b0;
    chk("t4_err", cmd_err, 1);
    chk("t4_busy", busy, 0);
    tick();
    chk("t4_err_pulse", cmd_err, 0);
    chk("t4_no_load", ctrl_rd_en_b, 0);
    chk("t4_busy2", busy, 0);
    // five commands back to back, no writebacks yet
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1;
      cmd_data = mk(2, 2, 2, 16*i, 'h80, 'h90, 'h100 + 16*i);
      tick();
    end
    chk("t3_ready_low", cmd_ready, 0);
    cmd_data = mk(2, 2, 2, 0, 0, 0, 'h3C0);
    tick();
    cmd_valid = 1'b0;
    repeat (200) tick();
    chk("t3_inflight_cap", ctrl_rd_en_b, 0);
    chk("t3_ready_back", cmd_ready, 1);
    chk("t3_busy", busy, 1);
    chk("t3_d_col", ctrl_col_mask, 'h0003);
    chk("t3_d_addr", ctrl_wr_addr_d, 'h100);
    base = done_cnt;
    core_writeback_valid = 1'b1;
    for (int i = 0; i < 400 && done_cnt - base < 5; i++) tick();
    core_writeback_valid = 1'b0;
    tick();
    chk("t3_done_count", done_cnt - base, 5);
    chk("t3_busy_fall", busy, 0);
    // long command followed by short one: second C job waits in the pending slot
    cmd_valid = 1'b1;
    cmd_data = mk(40, 16, 4, 'h000, 'h080, 'h050, 'h100);
    tick();
    cmd_data = mk(2, 5, 8, 'h300, 'h090, 'h250, 'h200);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 300 && !ctrl_rd_en_c; i++) tick();
    for (int i = 0; i < 42; i++) begin
      chk("t5_c_en", ctrl_rd_en_c, 1);
      chk("t5_c_addr", ctrl_rd_addr_c, i < 40 ? 'h050 + i : 'h250 + i - 40);
      tick();
    end
    chk("t5_c_end", ctrl_rd_en_c, 0);
    for (int i = 0; i < 100 && ctrl_col_mask == 16'h0; i++) tick();
    chk("t5_first_col", ctrl_col_mask, 'h000F);
    chk("t5_first_addr", ctrl_wr_addr_d, 'h100);
    core_writeback_valid = 1'b1;
    repeat (39) tick();
    chk("t5_no_done", done_irq, 0);
    tick();
    chk("t5_done_a", done_irq, 1);
    chk("t5_second_col", ctrl_col_mask, 'h00FF);
    chk("t5_second_addr", ctrl_wr_addr_d, 'h200);
    tick();
    chk("t5_gap", done_irq, 0);
    tick();
    core_writeback_valid = 1'b0;
    chk("t5_done_b", done_irq, 1);
    tick();
    chk("t5_busy", busy, 0);
    // reset in the middle of a weight load
    cmd_valid = 1'b1;
    cmd_data = mk(4, 4, 4, 'h0, 'h3F0, 'h0, 'h0);
    tick();
    cmd_valid = 1'b0;
    repeat (2) tick();
    chk("t6_loading", ctrl_rd_en_b, 1);
    chk("t6_load_addr", ctrl_rd_addr_b, 'h3F1);
    rst = 1'b1;
    tick();
    chk("t6_rd_en_b", ctrl_rd_en_b, 0);
    chk("t6_addr_b", ctrl_rd_addr_b, 0);
    chk("t6_accept", ctrl_b_accept_w, 0);
    chk("t6_busy", busy, 0);
    chk("t6_ready", cmd_ready, 1);
    chk("t6_vpu", ctrl_vpu_mode, 3'b001);
    chk("t6_perf_busy", perf_busy_cycles, 0);
    chk("t6_perf_cmds", perf_cmds_done, 0);
    rst = 1'b0;
    base = done_cnt;
    repeat (30) tick();
    chk("t6_no_a", ctrl_rd_en_a, 0);
    chk("t6_idle", busy, 0);
    chk("t6_no_done", done_cnt - base, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
